event_timestamper: RTL and testbench
====================================

Name: event_timestamper

Overview:
- Consumes the free-running 32-bit tick count produced by the system timebase.
- Stamps rising edges on up to NCH asynchronous event lines with that count.
- Buffers each stamp in a small first-word-fall-through FIFO, drained by a downstream reader (bus slave or UART packetiser) through a valid/ready handshake.
- Tracks lost events when the FIFO is full.

Parameters:
- NCH, 4, number of event input channels (1..8).
- DEPTH, 8, FIFO entries; power of two, 2..64.
- AW, 3, FIFO address width; must equal log2(DEPTH).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- time_in  input  32  current tick count from the timebase.
- event_in  input  NCH  asynchronous event lines.
- enable  input  1  when 0, detected edges are discarded (not pushed, not counted as drops).
- out_valid  output  1  FIFO head entry is valid.
- out_ready  input  1  reader accepts the head entry.
- out_chan  output  NCH  bitmask of channels that rose in the stamped cycle.
- out_time  output  32  time_in value captured with the entry.
- fill  output  AW+1  current number of FIFO entries (0..DEPTH).
- overflow  output  1  sticky: at least one event was dropped.
- drop_count  output  8  saturating count of dropped pushes.
- clear_overflow  input  1  synchronous clear of overflow and drop_count.

Behaviour:
- Reset: clock is `clk`; reset is asynchronous and active-high, port `reset`. While reset is asserted, all of the following are held at 0:
  - all sync registers;
  - FIFO pointers, so fill=0 and out_valid=0;
  - overflow and drop_count.
  - out_chan and out_time are 0 while fill=0.
- Reset mid-operation: FIFO contents are discarded immediately.
- Synchroniser: three flops per channel, s1 -> s2 -> s3. rise[i] = s2[i] & ~s3[i].
  - A line already high at reset release produces exactly one event.
- Push condition: at a clk edge where enable=1 and rise!=0.
  - Entry written = {rise, time_in sampled at that same edge}.
  - Latency: event_in rises before edge k, so s1 is set at k, s2 at k+1, and the push occurs at edge k+2.
  - out_valid is high from edge k+2 onward if the FIFO was empty.
- Multiple channels rising in the same cycle produce one entry with several mask bits set.
- time_in is opaque: 0xFFFFFFFF and wrap to 0 are stored as-is, with no arithmetic.
- Pop condition: out_valid & out_ready at a clk edge.
  - First-word fall-through: out_chan/out_time always show the head entry combinationally from the memory at the read pointer.
  - out_chan/out_time are forced to 0 when empty.
- Pointers are AW+1 bits.
  - fill = wr_ptr - rd_ptr.
  - Full when fill==DEPTH.
  - Pointers wrap naturally modulo 2*DEPTH.
- Push and pop in the same cycle:
  - If not full: both happen, fill unchanged.
  - If full: pop frees the slot and the push is accepted, so the entry is not dropped.
  - If empty: the push happens; the pop cannot, because out_valid=0.
- Drop: a push request while full with no simultaneous pop.
  - Entry is discarded.
  - overflow <= 1.
  - drop_count <= drop_count+1, saturating at 255.
- clear_overflow:
  - Sets overflow and drop_count to 0 at the next edge.
  - If a drop occurs in the same cycle, the result is overflow=1, drop_count=1.
- enable=0:
  - The synchroniser keeps running, so no spurious event appears when enable returns to 1 with the line high.
  - Pops continue normally.
- Held-high or glitch-free lines yield one event per rising edge only.
- A pulse shorter than one clk period may be missed; this is not an error.

Test Plan:
1. Reset release with event_in=0, time_in=0xFFFFFFFF -> out_valid=0, fill=0, overflow=0, out_time=0.
2. event_in[2] rises before edge k, time_in=0x00000010 at edge k+2 -> at k+2 out_valid=1, out_chan=4'b0100, out_time=0x00000010, fill=1; pop with out_ready=1 -> fill=0.
3. event_in[0] and event_in[3] rise simultaneously, time_in=0xFFFFFFFF, then time_in wraps to 0 and event_in[1] rises -> two entries {4'b1001, 0xFFFFFFFF} then {4'b0010, 0x00000000}.
4. out_ready=0, 10 distinct events with DEPTH=8 -> fill=8, overflow=1, drop_count=2; drain gives the first 8 stamps in order.
5. FIFO full, simultaneous push and pop -> fill stays 8, no drop; clear_overflow in the same cycle as a drop -> overflow=1, drop_count=1.
6. enable=0 while event_in[1] rises, then enable=1 with the line still high -> no entry; assert reset with fill=5 -> fill=0, out_valid=0 immediately.

Source files
------------

// File: rtl/event_timestamper.sv
// Time-stamps rising edges on asynchronous event lines with the system tick count
// and queues the stamps in a first-word-fall-through FIFO with drop accounting.
module event_timestamper #(
   parameter int NCH   = 4,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      time_in,
   input  logic [NCH-1:0]   event_in,
   input  logic             enable,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NCH-1:0]   out_chan,
   output logic [31:0]      out_time,
   output logic [AW:0]      fill,
   output logic             overflow,
   output logic [7:0]       drop_count,
   input  logic             clear_overflow
);

   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

   logic [NCH-1:0]    r_s1;
   logic [NCH-1:0]    r_s2;
   logic [NCH-1:0]    r_s3;
   logic [NCH+31:0]   r_mem [DEPTH];
   logic [AW:0]       r_wrPtr;
   logic [AW:0]       r_rdPtr;
   logic              r_overflow;
   logic [7:0]        r_dropCount;

   logic [NCH-1:0]    w_rise;
   logic [AW:0]       w_fill;
   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_pushReq;
   logic              w_push;
   logic              w_drop;
   logic [NCH+31:0]   w_head;

   // s3 keeps following s2 even while disabled, so a line held high across enable adds no event
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1 <= '0;
         r_s2 <= '0;
         r_s3 <= '0;
      end else begin
         r_s1 <= event_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_rise    = r_s2 & ~r_s3;
   assign w_fill    = r_wrPtr - r_rdPtr;
   assign w_empty   = (w_fill == '0);
   assign w_full    = (w_fill == LP_DEPTH);
   assign w_pop     = ~w_empty & out_ready;
   assign w_pushReq = enable & (|w_rise);
   assign w_push    = w_pushReq & (~w_full | w_pop);
   assign w_drop    = w_pushReq & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr[AW-1:0]] <= {w_rise, time_in};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + (AW+1)'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + (AW+1)'(1);
         end
      end
   end

   // A drop in the clearing cycle must survive the clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overflow  <= 1'b0;
         r_dropCount <= 8'd0;
      end else if (clear_overflow) begin
         r_overflow  <= w_drop;
         r_dropCount <= w_drop ? 8'd1 : 8'd0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_dropCount != 8'hFF) begin
            r_dropCount <= r_dropCount + 8'd1;
         end
      end
   end

   assign w_head     = w_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];
   assign out_valid  = ~w_empty;
   assign out_chan   = w_head[NCH+31:32];
   assign out_time   = w_head[31:0];
   assign fill       = w_fill;
   assign overflow   = r_overflow;
   assign drop_count = r_dropCount;

endmodule

// File: tb/tb_event_timestamper.sv
// Bench for event_timestamper: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the stamping rules.
module tb_event_timestamper;

   logic        clk;
   logic        reset;
   logic [31:0] time_in;
   logic [3:0]  event_in;
   logic        enable;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_chan;
   logic [31:0] out_time;
   logic [3:0]  fill;
   logic        overflow;
   logic [7:0]  drop_count;
   logic        clear_overflow;

   int vectors;
   int miscompares;

   // Reference model: entries as {mask, time}, event-line samples taken at each edge
   logic [35:0] mq[$];
   logic [3:0]  evHist[$];
   logic        mOv;
   int          mDrop;

   event_timestamper #(.NCH(4), .DEPTH(8), .AW(3)) dut (
      .clk(clk),
      .reset(reset),
      .time_in(time_in),
      .event_in(event_in),
      .enable(enable),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_chan(out_chan),
      .out_time(out_time),
      .fill(fill),
      .overflow(overflow),
      .drop_count(drop_count),
      .clear_overflow(clear_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic modelReset();
      mq.delete();
      evHist.delete();
      repeat (3) evHist.push_back(4'b0000);
      mOv   = 1'b0;
      mDrop = 0;
   endtask

   // A line seen high two edges ago and low three edges ago yields a stamp at this edge
   task automatic tick();
      logic [3:0] rise;
      bit pop, pushReq, drop;
      rise    = evHist[evHist.size()-2] & ~evHist[evHist.size()-3];
      pop     = (mq.size() != 0) && out_ready;
      pushReq = enable && (rise != 4'b0000);
      drop    = pushReq && (mq.size() == 8) && !pop;
      if (pop) void'(mq.pop_front());
      if (pushReq && !drop) mq.push_back({rise, time_in});
      if (clear_overflow) begin
         mOv   = drop;
         mDrop = drop ? 1 : 0;
      end else if (drop) begin
         mOv = 1'b1;
         if (mDrop < 255) mDrop++;
      end
      evHist.push_back(event_in);
      if (evHist.size() > 8) void'(evHist.pop_front());
      @(posedge clk);
      #1;
   endtask

   task automatic fireEvent(input logic [3:0] mask);
      event_in = mask;
      time_in  = $urandom;
      tick();
      event_in = 4'b0000;
      time_in  = $urandom;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; event_in = 4'b0000; time_in = 32'hFFFFFFFF;
      enable = 1'b1; out_ready = 1'b0; clear_overflow = 1'b0;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 1'b0 || fill !== 4'd0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_hold: valid=%b fill=%0d ovf=%b drops=%0d, want 0 0 0 0", out_valid, fill, overflow, drop_count);
      end
      reset = 1'b0;
      tick();
      tick();
      vectors++;
      if (out_valid !== 1'b0 || fill !== 4'd0 || overflow !== 1'b0 || out_time !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL reset_release: valid=%b fill=%0d ovf=%b time=%h, want 0 0 0 0", out_valid, fill, overflow, out_time);
      end
   endtask

   task automatic test_single_event();
      event_in = 4'b0100; time_in = 32'd1;
      tick();
      time_in = 32'd2;
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL latency_early: valid=%b, want 0", out_valid);
      end
      time_in = 32'h10;
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_chan !== 4'b0100 || out_time !== 32'h10 || fill !== 4'd1) begin
         miscompares++;
         $display("[TB] FAIL single_stamp: valid=%b chan=%b time=%h fill=%0d, want 1 0100 00000010 1", out_valid, out_chan, out_time, fill);
      end
      out_ready = 1'b1;
      tick();
      vectors++;
      if (fill !== 4'd0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL single_pop: fill=%0d valid=%b, want 0 0", fill, out_valid);
      end
      out_ready = 1'b0; event_in = 4'b0000;
      repeat (3) tick();
   endtask

   task automatic test_time_wrap();
      event_in = 4'b1001; time_in = 32'h5;
      tick();
      tick();
      time_in = 32'hFFFFFFFF;
      tick();
      time_in = 32'h0; event_in = 4'b1011;
      repeat (3) tick();
      vectors++;
      if (fill !== 4'd2 || out_chan !== 4'b1001 || out_time !== 32'hFFFFFFFF) begin
         miscompares++;
         $display("[TB] FAIL wrap_first: fill=%0d chan=%b time=%h, want 2 1001 ffffffff", fill, out_chan, out_time);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++;
      if (fill !== 4'd1 || out_chan !== 4'b0010 || out_time !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL wrap_second: fill=%0d chan=%b time=%h, want 1 0010 00000000", fill, out_chan, out_time);
      end
      out_ready = 1'b1; event_in = 4'b0000;
      repeat (3) tick();
      out_ready = 1'b0;
      vectors++;
      if (fill !== 4'd0) begin
         miscompares++;
         $display("[TB] FAIL wrap_drain: fill=%0d, want 0", fill);
      end
   endtask

   task automatic test_overflow();
      logic [35:0] expQ[$];
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) fireEvent(4'($urandom_range(1, 15)));
      tick();
      vectors++;
      if (fill !== 4'd8 || overflow !== 1'b1 || drop_count !== 8'd2) begin
         miscompares++;
         $display("[TB] FAIL overflow_state: fill=%0d ovf=%b drops=%0d, want 8 1 2", fill, overflow, drop_count);
      end
      expQ = mq;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if ({out_chan, out_time} !== expQ[i]) begin
            miscompares++;
            $display("[TB] FAIL drain_order[%0d]: got %b/%h, want %b/%h", i, out_chan, out_time, expQ[i][35:32], expQ[i][31:0]);
         end
         tick();
      end
      out_ready = 1'b0;
      vectors++;
      if (fill !== 4'd0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL overflow_drain: fill=%0d valid=%b, want 0 0", fill, out_valid);
      end
   endtask

   task automatic test_full_push_pop();
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      vectors++;
      if (overflow !== 1'b0 || drop_count !== 8'd0) begin
         miscompares++;
         $display("[TB] FAIL clear: ovf=%b drops=%0d, want 0 0", overflow, drop_count);
      end
      for (int i = 0; i < 9; i++) fireEvent(4'b0001);
      vectors++;
      if (fill !== 4'd8) begin
         miscompares++;
         $display("[TB] FAIL fill_to_full: fill=%0d, want 8", fill);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++;
      if (fill !== 4'd8 || overflow !== 1'b0 || drop_count !== 8'd0) begin
         miscompares++;
         $display("[TB] FAIL full_push_pop: fill=%0d ovf=%b drops=%0d, want 8 0 0", fill, overflow, drop_count);
      end
      fireEvent(4'b0010);
      fireEvent(4'b0100);
      tick();
      vectors++;
      if (overflow !== 1'b1 || drop_count !== 8'd2) begin
         miscompares++;
         $display("[TB] FAIL two_drops: ovf=%b drops=%0d, want 1 2", overflow, drop_count);
      end
      fireEvent(4'b1000);
      clear_overflow = 1'b1;
      tick();
      clear_overflow = 1'b0;
      vectors++;
      if (overflow !== 1'b1 || drop_count !== 8'd1) begin
         miscompares++;
         $display("[TB] FAIL clear_with_drop: ovf=%b drops=%0d, want 1 1", overflow, drop_count);
      end
      out_ready = 1'b1;
      repeat (10) tick();
      out_ready = 1'b0;
   endtask

   task automatic test_enable_and_reset();
      enable = 1'b0; event_in = 4'b0010;
      repeat (4) tick();
      enable = 1'b1;
      repeat (4) tick();
      vectors++;
      if (fill !== 4'd0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL enable_gate: fill=%0d valid=%b, want 0 0", fill, out_valid);
      end
      event_in = 4'b0000;
      tick();
      for (int i = 0; i < 5; i++) fireEvent(4'b0001);
      tick();
      vectors++;
      if (fill !== 4'd5) begin
         miscompares++;
         $display("[TB] FAIL prefill: fill=%0d, want 5", fill);
      end
      reset = 1'b1;
      modelReset();
      #1;
      vectors++;
      if (fill !== 4'd0 || out_valid !== 1'b0 || out_time !== 32'd0) begin
         miscompares++;
         $display("[TB] FAIL async_reset: fill=%0d valid=%b time=%h, want 0 0 0", fill, out_valid, out_time);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 1100; i++) begin
         event_in       = 4'($urandom);
         time_in        = $urandom;
         enable         = (i >= 400) || ($urandom_range(0, 7) != 0);
         out_ready      = (i < 400) && ($urandom_range(0, 3) != 0);
         clear_overflow = (i < 400) && ($urandom_range(0, 15) == 0);
         tick();
         vectors++;
         if (out_valid !== (mq.size() != 0) || fill !== 4'(mq.size())) begin
            miscompares++;
            $display("[TB] FAIL rand_level[%0d]: valid=%b fill=%0d, want %b %0d", i, out_valid, fill, mq.size() != 0, mq.size());
         end
         vectors++;
         if ({out_chan, out_time} !== ((mq.size() != 0) ? mq[0] : 36'd0)) begin
            miscompares++;
            $display("[TB] FAIL rand_head[%0d]: got %b/%h", i, out_chan, out_time);
         end
         vectors++;
         if (overflow !== mOv || drop_count !== 8'(mDrop)) begin
            miscompares++;
            $display("[TB] FAIL rand_drop[%0d]: ovf=%b drops=%0d, want %b %0d", i, overflow, drop_count, mOv, mDrop);
         end
      end
      vectors++;
      if (drop_count !== 8'd255) begin
         miscompares++;
         $display("[TB] FAIL saturate: drops=%0d, want 255", drop_count);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_single_event();
      test_time_wrap();
      test_overflow();
      test_full_push_pop();
      test_enable_and_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
